slave_send_packet: RTL and testbench

- Transmit-side packet builder for the USB slave.
- Accepts a one-cycle request from the slave controller carrying a 4-bit PID.
- Handshake PIDs are emitted as a single PID byte. DATA0/DATA1 packets are emitted as PID byte, endpoint TX FIFO payload, then CRC16.
- Sits between the slave controller (sendPacketWEn/sendPacketPID/sendPacketRdy) and the SIE transmitter byte interface.

---
 rtl/slave_send_packet_if.sv | 51 +++++
 rtl/slave_send_packet.sv | 154 +++++++++++++++
 tb/tb_slave_send_packet.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_send_packet_if.sv
// Bundle between the slave controller, TX FIFO and SIE transmitter.
// pktLen is present only when SLV_SEND_PKT_LEN_EN is defined.
interface slave_send_packet_if #(
    parameter int unsigned CNT_W = 7
);
    logic             sendPacketWEn;
    logic [3:0]       sendPacketPID;
    logic             sendPacketRdy;
    logic             fifoRdEn;
    logic [7:0]       fifoData;
    logic             fifoEmpty;
    logic [7:0]       txData;
    logic             txValid;
    logic             txLast;
    logic             txReady;
`ifdef SLV_SEND_PKT_LEN_EN
    logic [CNT_W-1:0] pktLen;
`endif

    modport slave (
        input  sendPacketWEn,
        input  sendPacketPID,
        output sendPacketRdy,
        output fifoRdEn,
        input  fifoData,
        input  fifoEmpty,
        output txData,
        output txValid,
        output txLast,
        input  txReady
`ifdef SLV_SEND_PKT_LEN_EN
        , output pktLen
`endif
    );

    modport master (
        output sendPacketWEn,
        output sendPacketPID,
        input  sendPacketRdy,
        input  fifoRdEn,
        output fifoData,
        output fifoEmpty,
        input  txData,
        input  txValid,
        input  txLast,
        output txReady
`ifdef SLV_SEND_PKT_LEN_EN
        , input pktLen
`endif
    );
endinterface

// File: rtl/slave_send_packet.sv
// USB slave transmit packet builder: PID byte, optional FIFO payload and CRC16.
// Optional pktLen output enabled by SLV_SEND_PKT_LEN_EN.
module slave_send_packet #(
    parameter int unsigned MAX_PKT_BYTES = 64,
    parameter int unsigned CNT_W         = 7
) (
    input  logic               clk,
    input  logic               rst,
    slave_send_packet_if.slave bus
);
    localparam logic [3:0]  PID_DATA0 = 4'h3;
    localparam logic [3:0]  PID_DATA1 = 4'hB;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'hA001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_PID,
        S_REQ,
        S_WAIT,
        S_SEND_DATA,
        S_CRC_LO,
        S_CRC_HI
    } state_t;

    state_t           state, state_d;
    logic [7:0]       tx_data, tx_data_d;
    logic             tx_valid, tx_valid_d;
    logic             tx_last, tx_last_d;
    logic [15:0]      crc, crc_d;
    logic [CNT_W-1:0] count, count_d;
    logic             rd_en_c;

    // Reflected USB CRC16, one byte LSB-first
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            crc      <= CRC_INIT;
            count    <= '0;
        end else begin
            state    <= state_d;
            tx_data  <= tx_data_d;
            tx_valid <= tx_valid_d;
            tx_last  <= tx_last_d;
            crc      <= crc_d;
            count    <= count_d;
        end
    end

    always_comb begin
        state_d    = state;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        tx_last_d  = tx_last;
        crc_d      = crc;
        count_d    = count;
        rd_en_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.sendPacketWEn) begin
                    tx_data_d  = {~bus.sendPacketPID, bus.sendPacketPID};
                    tx_valid_d = 1'b1;
                    tx_last_d  = !((bus.sendPacketPID == PID_DATA0) ||
                                   (bus.sendPacketPID == PID_DATA1));
                    crc_d      = CRC_INIT;
                    count_d    = '0;
                    state_d    = S_SEND_PID;
                end
            end
            S_SEND_PID: begin
                if (bus.txReady) begin
                    tx_valid_d = 1'b0;
                    if (tx_last) begin
                        tx_last_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.fifoEmpty || (count == CNT_W'(MAX_PKT_BYTES))) begin
                    tx_data_d  = ~crc[7:0];
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    state_d    = S_CRC_LO;
                end else begin
                    rd_en_c = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tx_data_d  = bus.fifoData;
                tx_valid_d = 1'b1;
                state_d    = S_SEND_DATA;
            end
            S_SEND_DATA: begin
                if (bus.txReady) begin
                    crc_d      = crc16_upd(crc, tx_data);
                    count_d    = count + CNT_W'(1);
                    tx_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_CRC_LO: begin
                if (bus.txReady) begin
                    tx_data_d = ~crc[15:8];
                    tx_last_d = 1'b1;
                    state_d   = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (bus.txReady) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SLV_SEND_PKT_LEN_EN
    logic [CNT_W-1:0] pkt_len;

    // Captured only when a data packet's final CRC byte is accepted
    always_ff @(posedge clk) begin
        if (rst)                                pkt_len <= '0;
        else if (state == S_CRC_HI && bus.txReady) pkt_len <= count;
    end

    assign bus.pktLen = pkt_len;
`endif

    // Rdy drops on the request cycle itself so the controller never sees a stale ready
    assign bus.sendPacketRdy = (state == S_IDLE) && !bus.sendPacketWEn;
    assign bus.fifoRdEn      = rd_en_c;
    assign bus.txData        = tx_data;
    assign bus.txValid       = tx_valid;
    assign bus.txLast        = tx_last;
endmodule

// File: tb/tb_slave_send_packet.sv
// Scoreboard bench for slave_send_packet: expected bytes queued per request, compared on handshake.
module tb_slave_send_packet;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned MAXB  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slave_send_packet_if #(.CNT_W(CNT_W)) bus ();

    slave_send_packet #(.MAX_PKT_BYTES(MAXB), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // TX FIFO model: one-cycle read latency
    logic [7:0] fifo_mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_flush = 1'b0;

    always @(posedge clk) begin
        if (fifo_flush) rd_ptr <= wr_ptr;
        else if (bus.fifoRdEn && (rd_ptr != wr_ptr)) begin
            bus.fifoData <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end
    assign bus.fifoEmpty = (rd_ptr == wr_ptr);

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] pay_q [$];
    int         checks = 0;
    int         failures = 0;
    int         rd_pulses = 0;
    logic       held = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_fifo();
        foreach (pay_q[i]) begin
            fifo_mem[wr_ptr] = pay_q[i];
            wr_ptr++;
        end
    endtask

    task automatic flush_fifo();
        @(negedge clk);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    // Expected byte stream: PID, then for data PIDs n payload bytes and inverted CRC16 (lo, hi)
    task automatic expect_pkt(input logic [3:0] pid, input int n);
        logic        is_data;
        logic [15:0] c;
        exp_t        e;
        is_data = (pid == 4'h3) || (pid == 4'hB);
        e.data = {~pid, pid};
        e.last = !is_data;
        exp_q.push_back(e);
        if (is_data) begin
            c = 16'hFFFF;
            for (int i = 0; i < n; i++) begin
                c = c ^ {8'h00, pay_q[i]};
                for (int b = 0; b < 8; b++)
                    c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
                e.data = pay_q[i];
                e.last = 1'b0;
                exp_q.push_back(e);
            end
            e.data = ~c[7:0];
            e.last = 1'b0;
            exp_q.push_back(e);
            e.data = ~c[15:8];
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // One clock of monitoring; drives inputs after negedge and samples 1ns later
    task automatic tick(input bit stall, input bit inject);
        exp_t e;
        @(negedge clk);
        bus.sendPacketWEn = inject;
        if (inject) bus.sendPacketPID = 4'h2;
        bus.txReady = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        #1;
        if (inject) check("rdy_busy", 32'(bus.sendPacketRdy), 32'd0);
        if (bus.fifoRdEn) rd_pulses++;
        if (held) begin
            check("stall_valid", 32'(bus.txValid), 32'd1);
            check("stall_data", 32'(bus.txData), 32'(held_data));
            check("stall_last", 32'(bus.txLast), 32'(held_last));
        end
        held      = bus.txValid && !bus.txReady;
        held_data = bus.txData;
        held_last = bus.txLast;
        if (bus.txValid && bus.txReady) begin
            if (exp_q.size() == 0) check("extra_byte", 32'(bus.txData), 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(bus.txData), 32'(e.data));
                check("tx_last", 32'(bus.txLast), 32'(e.last));
            end
        end
    endtask

    task automatic send_req(input logic [3:0] pid);
        @(negedge clk);
        bus.sendPacketWEn = 1'b1;
        bus.sendPacketPID = pid;
        bus.txReady       = 1'b1;
        #1;
        check("rdy_on_wen", 32'(bus.sendPacketRdy), 32'd0);
    endtask

    task automatic run_pkt(input logic [3:0] pid, input int n, input bit stall);
        int budget;
        rd_pulses = 0;
        held      = 1'b0;
        expect_pkt(pid, n);
        send_req(pid);
        budget = 0;
        while (exp_q.size() > 0 && budget < 3000) begin
            tick(stall, stall && (budget == 6));
            budget++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
        bus.sendPacketWEn = 1'b0;
        bus.txReady       = 1'b1;
        #1;
        check("rdy_after", 32'(bus.sendPacketRdy), 32'd1);
        check("valid_after", 32'(bus.txValid), 32'd0);
    endtask

    initial begin
        int rem;
        int budget;
        bus.sendPacketWEn = 1'b0;
        bus.sendPacketPID = 4'h0;
        bus.txReady       = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rdy", 32'(bus.sendPacketRdy), 32'd1);
        check("rst_valid", 32'(bus.txValid), 32'd0);
        check("rst_last", 32'(bus.txLast), 32'd0);
        check("rst_data", 32'(bus.txData), 32'd0);
        check("rst_rden", 32'(bus.fifoRdEn), 32'd0);
`ifdef SLV_SEND_PKT_LEN_EN
        check("rst_pktlen", 32'(bus.pktLen), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // ACK with bytes sitting in the FIFO that must not be read
        pay_q = '{8'h11, 8'h22};
        load_fifo();
        pay_q.delete();
        run_pkt(4'h2, 0, 1'b0);
        check("ack_rdpulses", 32'(rd_pulses), 32'd0);
        check("ack_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
        flush_fifo();

        // Zero-length DATA0
        run_pkt(4'h3, 0, 1'b0);
        check("zlp_rdpulses", 32'(rd_pulses), 32'd0);
`ifdef SLV_SEND_PKT_LEN_EN
        check("zlp_pktlen", 32'(bus.pktLen), 32'd0);
`endif

        // DATA1 with four bytes
        pay_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        load_fifo();
        run_pkt(4'hB, 4, 1'b0);
        check("d1_rdpulses", 32'(rd_pulses), 32'd4);
`ifdef SLV_SEND_PKT_LEN_EN
        check("d1_pktlen", 32'(bus.pktLen), 32'd4);
`endif

        // DATA0 with more than a max packet in the FIFO
        pay_q.delete();
        for (int i = 0; i < 70; i++) pay_q.push_back(8'(i * 3 + 1));
        load_fifo();
        run_pkt(4'h3, 64, 1'b0);
        check("max_rdpulses", 32'(rd_pulses), 32'd64);
        check("max_fifo_left", 32'(wr_ptr - rd_ptr), 32'd6);
`ifdef SLV_SEND_PKT_LEN_EN
        check("max_pktlen", 32'(bus.pktLen), 32'd64);
`endif

        // NAK leaves leftovers and pktLen alone
        run_pkt(4'hA, 0, 1'b0);
        check("nak_fifo_left", 32'(wr_ptr - rd_ptr), 32'd6);
`ifdef SLV_SEND_PKT_LEN_EN
        check("nak_pktlen", 32'(bus.pktLen), 32'd64);
`endif
        flush_fifo();

        // DATA1 with random txReady stalls and a stray request mid-packet
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        load_fifo();
        run_pkt(4'hB, 9, 1'b1);
        check("stall_rdpulses", 32'(rd_pulses), 32'd9);
`ifdef SLV_SEND_PKT_LEN_EN
        check("stall_pktlen", 32'(bus.pktLen), 32'd9);
`endif

        // Reset in the middle of a payload
        pay_q.delete();
        for (int i = 0; i < 10; i++) pay_q.push_back(8'(8'hA0 + i));
        load_fifo();
        held = 1'b0;
        expect_pkt(4'h3, 10);
        send_req(4'h3);
        budget = 0;
        while (exp_q.size() > 8 && budget < 200) begin
            tick(1'b0, 1'b0);
            budget++;
        end
        check("pre_rst_progress", 32'(exp_q.size()), 32'd8);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.txValid), 32'd0);
        check("mid_rst_rdy", 32'(bus.sendPacketRdy), 32'd1);
        check("mid_rst_rden", 32'(bus.fifoRdEn), 32'd0);
`ifdef SLV_SEND_PKT_LEN_EN
        check("mid_rst_pktlen", 32'(bus.pktLen), 32'd0);
`endif
        rem = wr_ptr - rd_ptr;
        rd_pulses = 0;
        held = 1'b0;
        repeat (5) tick(1'b0, 1'b0);
        check("post_rst_rdpulses", 32'(rd_pulses), 32'd0);
        check("post_rst_fifo_left", 32'(wr_ptr - rd_ptr), 32'(rem));
        flush_fifo();
        run_pkt(4'hA, 0, 1'b0);
        check("post_rst_nak_rdpulses", 32'(rd_pulses), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
